// File: rtl/sa_ram_fifo_ctrl_32x768.sv
//==============================================================================
// Module      : sa_ram_fifo_ctrl_32x768
// Description : Valid/ready FIFO controller around a 32x768 two-port RAM with
//               registered read address, plus a 2-entry output skid buffer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sa_ram_fifo_ctrl_32x768 #(
    parameter int DEPTH = 32,
    parameter int DW    = 768,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] ram_wa,
    output logic          ram_we,
    output logic [DW-1:0] ram_di,
    output logic [AW-1:0] ram_ra,
    output logic          ram_re,
    input  logic [DW-1:0] ram_dout,
    output logic [AW:0]   count,
    input  logic [31:0]   pwrbus_ram_pd,
    output logic [31:0]   ram_pd_out
);

    localparam logic [AW:0]   c_DEPTH  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] c_PTR_1  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [1:0]    c_SKID_1 = 2'd1;

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_rd_inflight;
    logic [1:0]    r_skid_cnt;
    logic [DW-1:0] r_skid0;
    logic [DW-1:0] r_skid1;

    logic          w_we;
    logic          w_re;
    logic          w_pop;
    logic [2:0]    w_skid_occ;

    // in_ready looks only at the registered occupancy, never at out_ready
    assign in_ready   = (r_count < c_DEPTH);
    assign w_we       = in_valid & in_ready & ~reset;
    assign out_valid  = (r_skid_cnt != 2'd0);
    assign out_data   = r_skid0;
    assign w_pop      = out_valid & out_ready;

    // Skid slots still claimed after this edge once in-flight data lands
    assign w_skid_occ = {1'b0, r_skid_cnt} + {2'b00, r_rd_inflight} - {2'b00, w_pop};
    assign w_re       = ~reset & (r_count != '0) & (w_skid_occ < 3'd2);

    assign ram_we     = w_we;
    assign ram_wa     = r_wr_ptr;
    assign ram_di     = in_data;
    assign ram_re     = w_re;
    assign ram_ra     = r_rd_ptr;
    assign count      = r_count;
    assign ram_pd_out = pwrbus_ram_pd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_rd_inflight <= 1'b0;
        end else begin
            if (w_we) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_1;
            end
            if (w_re) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_1;
            end
            r_count       <= r_count + {{AW{1'b0}}, w_we} - {{AW{1'b0}}, w_re};
            r_rd_inflight <= w_re;
        end
    end

    // Skid buffer: r_skid0 is always the head; capture fills the first free slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_skid_cnt <= 2'd0;
            r_skid0    <= '0;
            r_skid1    <= '0;
        end else begin
            case ({r_rd_inflight, w_pop})
                2'b01: begin
                    r_skid0    <= r_skid1;
                    r_skid_cnt <= r_skid_cnt - c_SKID_1;
                end
                2'b10: begin
                    if (r_skid_cnt == 2'd0) begin
                        r_skid0 <= ram_dout;
                    end else begin
                        r_skid1 <= ram_dout;
                    end
                    r_skid_cnt <= r_skid_cnt + c_SKID_1;
                end
                2'b11: begin
                    if (r_skid_cnt == 2'd1) begin
                        r_skid0 <= ram_dout;
                    end else begin
                        r_skid0 <= r_skid1;
                        r_skid1 <= ram_dout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/sa_ram_fifo_ctrl_32x768.md
# sa_ram_fifo_ctrl_32x768

FIFO controller that wraps the 32-entry x 768-bit two-port RAM (registered read address, synchronous write) into a valid/ready streaming FIFO. It owns the write/read pointers and occupancy, drives the RAM's `ra/re/wa/we/di` ports, and captures the RAM's one-cycle-late `dout` into a 2-entry output skid buffer. The result is full-throughput (1 beat/cycle) streaming to the downstream systolic-array consumer.

## Interface
- `DEPTH`, 32: RAM entries; power of two; pointer width `AW = log2(DEPTH)` = 5.
- `DW`, 768: data width.
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `in_valid` input 1: upstream beat valid.
- `in_ready` output 1: FIFO accepts beat; equals `count < DEPTH`.
- `in_data` input DW: upstream beat.
- `out_valid` output 1: head beat valid.
- `out_ready` input 1: downstream accepts head.
- `out_data` output DW: head beat.
- `ram_wa` output AW: to RAM `wa`.
- `ram_we` output 1: to RAM `we`.
- `ram_di` output DW: to RAM `di`.
- `ram_ra` output AW: to RAM `ra`.
- `ram_re` output 1: to RAM `re`.
- `ram_dout` input DW: from RAM `dout`, valid the cycle after `ram_re`.
- `count` output AW+1: RAM occupancy, 0..32; excludes skid-buffer entries.
- `pwrbus_ram_pd` input 32: passed unchanged to `ram_pd_out`.
- `ram_pd_out` output 32: to RAM `pwrbus_ram_pd`.

## Operation
- Write path, combinational:
  - `ram_we = in_valid & in_ready`
  - `ram_wa = wr_ptr`
  - `ram_di = in_data`
  - `wr_ptr` increments mod 32 on each write.
- Read issue, combinational:
  - `ram_re = (count != 0) & (skid_cnt + rd_inflight - pop < 2)`, where `pop = out_valid & out_ready`.
  - `ram_ra = rd_ptr`.
  - `rd_ptr` increments mod 32 on each issue.
- `rd_inflight`: register, next value = `ram_re`.
- When `rd_inflight` = 1, `ram_dout` is written into the skid buffer that cycle.
- Skid buffer: 2 entries, FIFO order.
  - `out_data` is the oldest entry.
  - `out_valid = (skid_cnt != 0)`.
  - A simultaneous capture and pop on one entry shifts correctly; order is preserved.
- `count` next value = `count + ram_we - ram_re`.
  - A simultaneous write and read leaves `count` unchanged.
- A read slot is freed at the `ram_re` edge. A write to that slot in the following cycle is safe, because capture samples the old `dout` at that same edge.
- No fall-through: every beat goes through the RAM.
- No read of an entry written in the same cycle: `count` is registered.
- Full: at `count` = 32, `in_ready` = 0 even if a read issues that cycle. Acceptance resumes the next cycle.
- Empty: at `count` = 0, `ram_re` = 0. Beats in flight or in the skid buffer still drain.
- Total capacity is 34 beats (32 RAM + 2 skid).
- `pwrbus_ram_pd` has no functional effect.

## Timing
- Reset, asynchronous, effective immediately:
  - `wr_ptr`, `rd_ptr`, `count`, `rd_inflight`, `skid_cnt` = 0.
  - Skid data = 0.
  - Outputs: `out_valid` = 0, `out_data` = 0, `in_ready` = 1, `count` = 0.
  - RAM controls: `ram_we` = 0 and `ram_re` = 0 while in reset.
  - RAM contents are not reset.
- Reset mid-stream: all queued beats are discarded. Post-reset behaviour is identical to power-up.
- Latency from accept edge at cycle 0 to head valid, into an empty FIFO:
  - cycle 1: `ram_re`.
  - cycle 2: `ram_dout` valid and captured.
  - cycle 3: `out_valid` = 1.
  - Total: 3 cycles.
- Throughput: 1 beat/cycle sustained in and out with `out_ready` held at 1.
- `out_valid`/`out_data` are stable until popped; no retraction.
- `in_ready` depends only on registered `count`. There is no combinational path from `out_ready` to `in_ready`.
- `ram_re` depends combinationally on `out_ready` through `pop`.

## Test plan
- Single beat: reset, then push `in_data` = 768'hA5 at cycle 0. Required: `ram_re` at cycle 1, `out_valid` = 1 with `out_data` = 768'hA5 at cycle 3, `count` back to 0 at cycle 2.
- Fill with downstream stalled: `out_ready` = 0, push beats 0..40. Required:
  - beats 0..33 accepted.
  - `count` reaches 32 and `skid_cnt` reaches 2.
  - `in_ready` = 0 from the first cycle `count` = 32.
  - Then raise `out_ready`: data 0..33 emerges in order with no duplication or drop.
- Streaming: `in_valid` = `out_ready` = 1 for 100 cycles with incrementing data. Required: after 3-cycle fill, one beat out per cycle, sequence exact, `count` ≤ 1.
- Pointer wrap: random `in_valid`/`out_ready` (50%) for 1000 beats. Required: scoreboard match, `count` never > 32, `count` never underflows, `ram_re` never asserted with `count` = 0.
- Full with simultaneous read: at `count` = 32 with `out_ready` = 1. Required: `ram_re` = 1, `ram_we` = 0 that cycle, `count` = 31 next cycle, `in_ready` = 1 next cycle.
- Reset mid-operation: assert `reset` with `count` = 10 and `skid_cnt` = 2. Required: `out_valid` = 0, `count` = 0 and `in_ready` = 1 immediately; the next pushed beat appears at the output after exactly 3 cycles.
